// File: rtl/tdc_run_ctrl.sv
// rtl/tdc_run_ctrl.sv - run/stop/lap controller for a two-digit BCD time counter
// Two buttons drive a four-state FSM that gates the tick prescaler, the 00-99 count and a lap-freeze display.
module tdc_run_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       btn_ss,
  input  logic       btn_lc,
  output logic [6:0] seg_1,
  output logic [6:0] seg_10,
  output logic       running,
  output logic       lap_hold
);

  localparam int unsigned   PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ss_sync_q, lc_sync_q;
  logic          ss_prev_q, lc_prev_q;
  logic          p_ss, p_lc;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    ones_q, ones_d, tens_q, tens_d;
  logic [3:0]    lap_ones_q, lap_ones_d, lap_tens_q, lap_tens_d;
  logic [3:0]    disp_ones, disp_tens;
  logic [6:0]    seg1_q, seg1_d, seg10_q, seg10_d;
  logic          run_q, run_d, lap_q, lap_d;
  logic          live, tick, clear, lap_load;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ss_sync_q <= 2'b00;
      lc_sync_q <= 2'b00;
      ss_prev_q <= 1'b0;
      lc_prev_q <= 1'b0;
    end else begin
      ss_sync_q <= {ss_sync_q[0], btn_ss};
      lc_sync_q <= {lc_sync_q[0], btn_lc};
      ss_prev_q <= ss_sync_q[1];
      lc_prev_q <= lc_sync_q[1];
    end
  end

  assign p_ss = ss_sync_q[1] & ~ss_prev_q;
  assign p_lc = lc_sync_q[1] & ~lc_prev_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Start/stop outranks lap/clear when both pulse in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (p_ss) state_d = RUN;
      RUN:  if (p_ss) state_d = STOP; else if (p_lc) state_d = LAP;
      LAP:  if (p_ss) state_d = STOP; else if (p_lc) state_d = RUN;
      STOP: if (p_ss) state_d = RUN;  else if (p_lc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    live       = (state_q == RUN) || (state_q == LAP);
    tick       = live && (pre_q == PRE_MAX);
    clear      = (state_q == STOP) && (state_d == IDLE);
    lap_load   = (state_q == RUN) && (state_d == LAP);
    run_d      = (state_d == RUN) || (state_d == LAP);
    lap_d      = (state_d == LAP);
    pre_d      = pre_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    lap_ones_d = lap_ones_q;
    lap_tens_d = lap_tens_q;
    if (clear) begin
      pre_d  = '0;
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (live) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
    end
    // The lap register captures the pre-increment count if a tick coincides.
    if (lap_load) begin
      lap_ones_d = ones_q;
      lap_tens_d = tens_q;
    end
    disp_ones = (state_q == LAP) ? lap_ones_q : ones_q;
    disp_tens = (state_q == LAP) ? lap_tens_q : tens_q;
    seg1_d    = seg7(disp_ones);
    seg10_d   = seg7(disp_tens);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_q      <= '0;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      lap_ones_q <= 4'd0;
      lap_tens_q <= 4'd0;
      seg1_q     <= 7'b1000000;
      seg10_q    <= 7'b1000000;
      run_q      <= 1'b0;
      lap_q      <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      lap_ones_q <= lap_ones_d;
      lap_tens_q <= lap_tens_d;
      seg1_q     <= seg1_d;
      seg10_q    <= seg10_d;
      run_q      <= run_d;
      lap_q      <= lap_d;
    end
  end

  assign seg_1    = seg1_q;
  assign seg_10   = seg10_q;
  assign running  = run_q;
  assign lap_hold = lap_q;

endmodule

// File: tb/tb_tdc_run_ctrl.sv
// tb/tb_tdc_run_ctrl.sv - self-checking bench for tdc_run_ctrl
// Integer-count reference model checked every cycle, plus a transition table and timed corner sequences.
module tb_tdc_run_ctrl;

  localparam int DIV    = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;
  localparam int M_LAP  = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       btn_ss, btn_lc;
  logic [6:0] seg_1, seg_10;
  logic       running, lap_hold;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] SEG [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  typedef struct {
    bit ss;
    bit lc;
    bit exp_run;
    bit exp_lap;
  } vec_t;
  vec_t vecs [12];

  tdc_run_ctrl #(.TICK_DIV(DIV)) dut (
    .CLK(CLK), .RST(RST), .btn_ss(btn_ss), .btn_lc(btn_lc),
    .seg_1(seg_1), .seg_10(seg_10), .running(running), .lap_hold(lap_hold)
  );

  always #10 CLK = ~CLK;

  // Reference model: count held as an integer 0..99, presses found from sampled-level history.
  int         m_st, m_cnt, m_lap, m_pre;
  logic [2:0] h_ss, h_lc;
  logic [6:0] e_seg1, e_seg10;
  logic       e_run, e_lap;
  logic       pss, plc, live, tick;
  int         nst, disp;

  always_comb begin
    pss  = h_ss[1] & ~h_ss[2];
    plc  = h_lc[1] & ~h_lc[2];
    live = (m_st == M_RUN) || (m_st == M_LAP);
    tick = live && (m_pre == DIV - 1);
    disp = (m_st == M_LAP) ? m_lap : m_cnt;
    nst  = m_st;
    if (pss) begin
      if (m_st == M_IDLE || m_st == M_STOP) nst = M_RUN;
      else                                  nst = M_STOP;
    end else if (plc) begin
      if (m_st == M_RUN)       nst = M_LAP;
      else if (m_st == M_LAP)  nst = M_RUN;
      else if (m_st == M_STOP) nst = M_IDLE;
    end
  end

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_st    <= M_IDLE;
      m_cnt   <= 0;
      m_lap   <= 0;
      m_pre   <= 0;
      h_ss    <= 3'b000;
      h_lc    <= 3'b000;
      e_seg1  <= SEG[0];
      e_seg10 <= SEG[0];
      e_run   <= 1'b0;
      e_lap   <= 1'b0;
    end else begin
      h_ss    <= {h_ss[1:0], btn_ss};
      h_lc    <= {h_lc[1:0], btn_lc};
      e_seg1  <= SEG[disp % 10];
      e_seg10 <= SEG[disp / 10];
      if (m_st == M_RUN && nst == M_LAP) m_lap <= m_cnt;
      if (m_st == M_STOP && nst == M_IDLE) begin
        m_cnt <= 0;
        m_pre <= 0;
      end else if (live) begin
        m_pre <= tick ? 0 : m_pre + 1;
        if (tick) m_cnt <= (m_cnt + 1) % 100;
      end
      m_st  <= nst;
      e_run <= (nst == M_RUN) || (nst == M_LAP);
      e_lap <= (nst == M_LAP);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0b required %0b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("model_seg_1",    32'(seg_1),    32'(e_seg1));
    chk("model_seg_10",   32'(seg_10),   32'(e_seg10));
    chk("model_running",  32'(running),  32'(e_run));
    chk("model_lap_hold", 32'(lap_hold), 32'(e_lap));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input bit ss, input bit lc);
    btn_ss = ss;
    btn_lc = lc;
    cyc(4);
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    cyc(4);
  endtask

  task automatic chk_disp(input string name, input int value);
    chk({name, "_seg_10"}, 32'(seg_10), 32'(SEG[value / 10]));
    chk({name, "_seg_1"},  32'(seg_1),  32'(SEG[value % 10]));
  endtask

  // Returns at the negedge right after the live count has just ticked to target.
  task automatic wait_tick(input int target);
    bit ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge CLK);
      if (m_cnt == target && m_pre == 0 && (m_st == M_RUN || m_st == M_LAP)) ok = 1'b1;
    end
    chk($sformatf("wait_tick_%0d", target), 32'(ok), 32'd1);
  endtask

  // From IDLE at 00: first increment TICK_DIV cycles after the state change, then a full wrap.
  task automatic start_check(input string tag);
    bit         seen    = 1'b0;
    int         changes = 0;
    logic [6:0] prev;
    btn_ss = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge CLK);
      if (running) seen = 1'b1;
    end
    chk({tag, "_running"}, 32'(seen), 32'd1);
    prev = seg_10;
    for (int i = 1; i <= 401; i++) begin
      @(negedge CLK);
      if (i == 10) btn_ss = 1'b0;
      if (i == 4) chk({tag, "_pre_tick_seg_1"}, 32'(seg_1), 32'(SEG[0]));
      if (i == 5) chk({tag, "_first_tick_seg_1"}, 32'(seg_1), 32'(SEG[1]));
      if (seg_10 != prev) changes++;
      prev = seg_10;
    end
    chk({tag, "_tens_steps"}, 32'(changes), 32'd10);
    chk_disp({tag, "_wrap"}, 0);
  endtask

  initial begin
    bit seen;
    int changes;
    bit prev_run;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0};

    RST    = 1'b1;
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    cyc(250);
    RST = 1'b0;
    cyc(100);
    chk_disp("idle", 0);
    chk("idle_running", 32'(running), 32'd0);
    chk("idle_lap_hold", 32'(lap_hold), 32'd0);

    for (int i = 0; i < 12; i++) begin
      press(vecs[i].ss, vecs[i].lc);
      chk($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].exp_run));
      chk($sformatf("vec%0d_lap_hold", i), 32'(lap_hold), 32'(vecs[i].exp_lap));
    end

    start_check("start1");

    wait_tick(23);
    btn_ss = 1'b1;
    cyc(4);
    btn_ss = 1'b0;
    cyc(196);
    chk_disp("stop_frozen", 23);
    chk("stop_running", 32'(running), 32'd0);
    press(1'b0, 1'b1);
    chk_disp("clear", 0);
    chk("clear_running", 32'(running), 32'd0);
    start_check("start2");

    wait_tick(15);
    btn_lc = 1'b1;
    cyc(4);
    btn_lc = 1'b0;
    cyc(4);
    chk("lap_hold_set", 32'(lap_hold), 32'd1);
    chk_disp("lap_frozen", 15);
    cyc(40);
    chk_disp("lap_still_frozen", 15);
    wait_tick(27);
    btn_lc = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge CLK);
      if (!lap_hold) seen = 1'b1;
    end
    chk("lap_release", 32'(seen), 32'd1);
    @(negedge CLK);
    chk_disp("lap_return", 27);
    btn_lc = 1'b0;
    cyc(4);

    btn_ss = 1'b1;
    btn_lc = 1'b1;
    cyc(4);
    chk("simul_running", 32'(running), 32'd0);
    chk("simul_lap_hold", 32'(lap_hold), 32'd0);
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    cyc(4);

    changes  = 0;
    prev_run = running;
    btn_ss   = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge CLK);
      if (running != prev_run) changes++;
      prev_run = running;
    end
    btn_ss = 1'b0;
    cyc(4);
    chk("held_transitions", 32'(changes), 32'd1);

    wait_tick(47);
    #3 RST = 1'b1;
    #2;
    chk_disp("async_rst", 0);
    chk("async_rst_running", 32'(running), 32'd0);
    chk("async_rst_lap_hold", 32'(lap_hold), 32'd0);
    cyc(3);
    RST = 1'b0;
    cyc(20);
    chk_disp("post_rst", 0);
    chk("post_rst_running", 32'(running), 32'd0);

    for (int s = 0; s < 400; s++) begin
      btn_ss = ($urandom_range(0, 2) == 0);
      btn_lc = ($urandom_range(0, 2) == 0);
      cyc($urandom_range(1, 12));
    end
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    cyc(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
